// File: rtl/coef_streamer_if.sv
// -----------------------------------------------------------------------------
// coef_streamer_if
// Groups the host write port, the frame request/stall inputs and the streamed
// coefficient outputs of coef_streamer into one bundle.
//
// Signals:
//   wr_en, wr_addr[3:0], wr_data[DW-1:0] : host write into the coefficient buffer
//   start                                : request to transmit one frame
//   hold                                 : downstream stall, freezes the current word
//   cf_load                              : frame-start strobe (word 0 on the bus)
//   coef_out[DW-1:0], coef_idx[3:0]      : current word and its index
//   coef_valid                           : coef_out/coef_idx are valid
//   busy                                 : frame in progress
//   done                                 : one-cycle pulse after the last word
//
// Modports:
//   master : the host/downstream side (drives the requests, observes the stream)
//   slave  : the streamer itself
// -----------------------------------------------------------------------------
interface coef_streamer_if #(
    parameter int DW = 8
);
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          hold;
    logic          cf_load;
    logic [DW-1:0] coef_out;
    logic          coef_valid;
    logic [3:0]    coef_idx;
    logic          busy;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_data, start, hold,
        input  cf_load, coef_out, coef_valid, coef_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, hold,
        output cf_load, coef_out, coef_valid, coef_idx, busy, done
    );
endinterface

// File: rtl/coef_streamer.sv
// -----------------------------------------------------------------------------
// coef_streamer
// Holds an NWORDS x DW coefficient buffer written by a host and, on request,
// streams the whole buffer out one word per accepted cycle to the matrix
// controller. Word 0 is flagged with cf_load; a one-cycle done pulse follows
// the last accepted word. A downstream hold freezes the presented word.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : coef_streamer_if.slave (write port, start/hold, streamed outputs)
//
// Every output is a flop. The next output values are derived from the next
// state and next index, so the first word appears one cycle after start is
// sampled and nothing combinational reaches the outputs.
// -----------------------------------------------------------------------------
module coef_streamer #(
    parameter int DW     = 8,
    parameter int NWORDS = 12
) (
    input  logic            clk,
    input  logic            reset,
    coef_streamer_if.slave  bus
);

    localparam logic [4:0] NWORDS_W = 5'(NWORDS);
    localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [3:0]    idx_r;
    logic [3:0]    idx_nxt_s;
    logic [DW-1:0] coef_buf_r [NWORDS];
    logic          wr_ok_s;
    logic [DW-1:0] word_nxt_s;

    logic          cf_load_r;
    logic          coef_valid_r;
    logic          busy_r;
    logic          done_r;
    logic [DW-1:0] coef_out_r;
    logic [3:0]    coef_idx_r;

    logic          cf_load_nxt_s;
    logic          coef_valid_nxt_s;
    logic          busy_nxt_s;
    logic          done_nxt_s;
    logic [DW-1:0] coef_out_nxt_s;
    logic [3:0]    coef_idx_nxt_s;

    // Write qualification: address in range and no frame being streamed
    always_comb begin
        wr_ok_s = 1'b0;
        if (bus.wr_en && ({1'b0, bus.wr_addr} < NWORDS_W) && (state_r != ST_SEND)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Coefficient buffer storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                coef_buf_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            coef_buf_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // FSM state and word index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // FSM next-state and next-index decode
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_SEND;
                    idx_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = 4'd0;
                end
            end
            ST_SEND: begin
                if (bus.hold) begin
                    state_nxt_s = ST_SEND;
                    idx_nxt_s   = idx_r;
                end else if (idx_r == LAST_IDX) begin
                    // last word accepted: index parks at 0, never wraps in-frame
                    state_nxt_s = ST_DONE;
                    idx_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_SEND;
                    idx_nxt_s   = idx_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 4'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 4'd0;
            end
        endcase
    end

    // Next word to present; a write committing at the same edge as start
    // must be visible in the first word, so it is forwarded here
    always_comb begin
        word_nxt_s = coef_buf_r[idx_nxt_s];
        if (wr_ok_s && (bus.wr_addr == idx_nxt_s)) begin
            word_nxt_s = bus.wr_data;
        end else begin
            word_nxt_s = coef_buf_r[idx_nxt_s];
        end
    end

    // Next output values derived from the next state
    always_comb begin
        cf_load_nxt_s    = 1'b0;
        coef_valid_nxt_s = 1'b0;
        busy_nxt_s       = 1'b0;
        coef_out_nxt_s   = '0;
        coef_idx_nxt_s   = 4'd0;
        done_nxt_s       = 1'b0;
        if (state_nxt_s == ST_SEND) begin
            cf_load_nxt_s    = (idx_nxt_s == 4'd0);
            coef_valid_nxt_s = 1'b1;
            busy_nxt_s       = 1'b1;
            coef_out_nxt_s   = word_nxt_s;
            coef_idx_nxt_s   = idx_nxt_s;
        end else begin
            cf_load_nxt_s    = 1'b0;
            coef_valid_nxt_s = 1'b0;
            busy_nxt_s       = 1'b0;
            coef_out_nxt_s   = '0;
            coef_idx_nxt_s   = 4'd0;
        end
        if (state_nxt_s == ST_DONE) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cf_load_r    <= 1'b0;
            coef_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            coef_out_r   <= '0;
            coef_idx_r   <= 4'd0;
        end else begin
            cf_load_r    <= cf_load_nxt_s;
            coef_valid_r <= coef_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            coef_out_r   <= coef_out_nxt_s;
            coef_idx_r   <= coef_idx_nxt_s;
        end
    end

    assign bus.cf_load    = cf_load_r;
    assign bus.coef_valid = coef_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.coef_out   = coef_out_r;
    assign bus.coef_idx   = coef_idx_r;

endmodule

// File: doc/coef_streamer.md
COEF_STREAMER -- requirements
Module: coef_streamer

Interface
REQ-001 Parameter DW, default 8, width of one coefficient word.
REQ-002 Parameter NWORDS, default 12, number of coefficient words per frame (maximum 16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset asserted when 0.
REQ-005 wr_en  input  1  host write strobe into the coefficient buffer.
REQ-006 wr_addr  input  4  buffer word index for the write.
REQ-007 wr_data  input  DW  coefficient word to store.
REQ-008 start  input  1  request to transmit one frame.
REQ-009 hold  input  1  downstream stall; freezes the current word while 1.
REQ-010 cf_load  output  1  frame-start strobe to the matrix controller; high only while word 0 is presented.
REQ-011 coef_out  output  DW  current coefficient word.
REQ-012 coef_valid  output  1  coef_out/coef_idx are valid.
REQ-013 coef_idx  output  4  index of the word on coef_out; matches the controller's 1-of-12 demux select.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 The block SHALL hold an NWORDS x DW register buffer, with every word zero after reset.
REQ-017 A write (wr_en=1, wr_addr<NWORDS, busy=0) SHALL update buf[wr_addr] at the clock edge; writes with wr_addr>=NWORDS or busy=1 SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, SEND and DONE; reset state is IDLE.
REQ-019 IDLE: start=1 -> SEND at the next edge; otherwise remain in IDLE.
REQ-020 On entering SEND, idx SHALL be 0 and the outputs in that cycle SHALL be: cf_load=1, coef_valid=1, coef_idx=0, coef_out=buf[0]; latency from start sampled to cf_load high is exactly 1 cycle.
REQ-021 SEND word acceptance: a word is accepted in each cycle with hold=0, and idx SHALL then increment at the next edge.
REQ-022 SEND with hold=1: idx SHALL be unchanged and all outputs SHALL be held stable, including cf_load if idx=0.
REQ-023 cf_load SHALL be 1 only in SEND with idx=0.
REQ-024 After word NWORDS-1 is accepted, the FSM SHALL go to DONE; idx SHALL not wrap within a frame.
REQ-025 DONE SHALL last exactly one cycle with done=1, busy=0 and coef_valid=0, then return to IDLE.
REQ-026 busy SHALL be 1 exactly in SEND.
REQ-027 coef_valid SHALL be 1 exactly in SEND.
REQ-028 Outside SEND, coef_out and coef_idx SHALL be 0.
REQ-029 start while in SEND or DONE SHALL be ignored, with no queuing.
REQ-030 Simultaneous wr_en and start in IDLE: the write SHALL commit at the same edge, and the frame SHALL transmit the new value.
REQ-031 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-032 reset=0 SHALL immediately force: state=IDLE, idx=0, buffer all zero, cf_load=0, coef_valid=0, coef_idx=0, coef_out=0, busy=0, done=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release, the block SHALL be in IDLE and wait for a new start.
REQ-034 Release of reset SHALL take effect on the first clk edge after reset=1.

Verification
REQ-035 Write buf[i]=0x10+i for i=0..11, pulse start -> next cycle cf_load=1, idx=0, coef_out=0x10; then 11 consecutive cycles with idx 1..11 and coef_out 0x11..0x1B; then done=1 for one cycle.
REQ-036 hold=1 for 3 cycles while idx=0, then while idx=5 -> cf_load stays 1 for 4 cycles; idx 5 (coef_out 0x15) is presented for 4 cycles; done arrives 6 cycles later than in REQ-035.
REQ-037 During a frame, write wr_addr=3 with 0xFF and pulse start at idx=4 -> buf[3] unchanged, no second frame, single done pulse.
REQ-038 With wr_addr=12, wr_data=0xAA, write then frame -> no word changes, and no output shows 0xAA.
REQ-039 reset=0 at idx=7 -> all outputs 0 at once, buffer reads back zero in the next frame, no done pulse.
REQ-040 wr_en (addr 0, 0x5A) and start in the same IDLE cycle -> first word of the frame is coef_out=0x5A with cf_load=1.
